// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss.cc BCD stopwatch driven by arrow-key levels.
//
// Rising edges of the key levels become commands:
//   up    - start/stop toggle          down  - clear (ignored while running)
//   left  - capture lap (recapture ok)  right - release lap
// A prescaler turns clk into a centisecond tick that advances a BCD cascade
// capped at 59:59.99. disp shows the lap register while lap_active, else the
// live counter, one clock after either changes.
//
// Ports:
//   clk        board clock
//   rst_n      asynchronous active-low reset
//   left/down/right/up  key levels, already synchronous to clk
//   disp       {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, registered
//   running    1 while counting
//   lap_active 1 while disp shows the frozen lap value
//   overflow   saturation flag (only with SW_SATURATE_EN)
//
// Build option: define SW_SATURATE_EN to saturate at 59:59.99 (pausing and
// raising overflow) instead of wrapping to 00:00.00.
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TICK_DIV = CLK_HZ / 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        left,
  input  logic        down,
  input  logic        right,
  input  logic        up,
  output logic [23:0] disp,
  output logic        running,
  output logic        lap_active
`ifdef SW_SATURATE_EN
  ,
  output logic        overflow
`endif
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause
  } state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [23:0]   cnt_q;
  logic [23:0]   lap_q;
  logic          left_q, down_q, right_q, up_q;

  logic          left_press, down_press, right_press, up_press;
  logic          clear, tick;
  logic [23:0]   cnt_inc;

  // One-digit-at-a-time BCD increment; 59:59.99 naturally wraps to zero.
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  lim;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[i*4 +: 4] == lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    left_press  = left  & ~left_q;
    down_press  = down  & ~down_q;
    right_press = right & ~right_q;
    up_press    = up    & ~up_q;
    clear       = down_press && (state_q != StRun);
    tick        = (state_q == StRun) && (presc_q == TickLast);
    cnt_inc     = bcd_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      cnt_q      <= '0;
      lap_q      <= '0;
      left_q     <= 1'b0;
      down_q     <= 1'b0;
      right_q    <= 1'b0;
      up_q       <= 1'b0;
      disp       <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
`ifdef SW_SATURATE_EN
      overflow   <= 1'b0;
`endif
    end else begin
      left_q  <= left;
      down_q  <= down;
      right_q <= right;
      up_q    <= up;
      disp    <= lap_active ? lap_q : cnt_q;

      if (clear) begin
        // Clear wins over a same-cycle up press and both lap commands.
        state_q    <= StIdle;
        running    <= 1'b0;
        presc_q    <= '0;
        cnt_q      <= '0;
        lap_q      <= '0;
        lap_active <= 1'b0;
`ifdef SW_SATURATE_EN
        overflow   <= 1'b0;
`endif
      end else begin
        if (state_q == StRun) begin
          presc_q <= tick ? '0 : presc_q + PW'(1);
        end

        // Lap capture sees cnt_q before this edge's tick is applied.
        if (left_press) begin
          lap_q      <= cnt_q;
          lap_active <= 1'b1;
        end else if (right_press) begin
          lap_active <= 1'b0;
        end

        if (up_press) begin
          unique case (state_q)
            StIdle: begin
              state_q <= StRun;
              running <= 1'b1;
            end
            StRun: begin
              state_q <= StPause;
              running <= 1'b0;
            end
            StPause: begin
`ifdef SW_SATURATE_EN
              if (!overflow) begin
                state_q <= StRun;
                running <= 1'b1;
              end
`else
              state_q <= StRun;
              running <= 1'b1;
`endif
            end
            default: begin
              state_q <= StIdle;
              running <= 1'b0;
            end
          endcase
        end

        if (tick) begin
`ifdef SW_SATURATE_EN
          if (cnt_q == 24'h595999) begin
            // Hold at max and park in PAUSE; only a clear gets out.
            overflow <= 1'b1;
            state_q  <= StPause;
            running  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
`else
          cnt_q <= cnt_inc;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int unsigned TD = 4;
  localparam int MaxCs = 359999;
`ifdef SW_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        left = 1'b0, down = 1'b0, right = 1'b0, up = 1'b0;
  logic [23:0] disp;
  logic        running, lap_active;
`ifdef SW_SATURATE_EN
  logic        overflow;
`endif

  stopwatch_ctrl #(
    .CLK_HZ  (400),
    .TICK_DIV(TD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .left      (left),
    .down      (down),
    .right     (right),
    .up        (up),
    .disp      (disp),
    .running   (running),
    .lap_active(lap_active)
`ifdef SW_SATURATE_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: time kept as a plain centisecond count.
  int          m_state;  // 0 idle, 1 run, 2 pause
  int          m_presc, m_cnt, m_lap;
  bit          m_lap_act, m_ovf;
  bit          p_l, p_d, p_r, p_u;
  logic [23:0] m_disp;

  function automatic logic [23:0] to_bcd(input int c);
    int mn, sc, cs;
    mn = c / 6000;
    sc = (c / 100) % 60;
    cs = c % 100;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_cnt = 0; m_lap = 0;
    m_lap_act = 0; m_ovf = 0;
    p_l = 0; p_d = 0; p_r = 0; p_u = 0;
    m_disp = '0;
  endtask

  task automatic model_step();
    bit          lp, dp, rp, up_p, tick;
    int          nstate;
    logic [23:0] nd;
    nd   = m_lap_act ? to_bcd(m_lap) : to_bcd(m_cnt);
    lp   = left && !p_l;
    dp   = down && !p_d;
    rp   = right && !p_r;
    up_p = up && !p_u;
    if (dp && m_state != 1) begin
      m_state = 0; m_presc = 0; m_cnt = 0; m_lap = 0; m_lap_act = 0; m_ovf = 0;
    end else begin
      tick = (m_state == 1) && (m_presc == TD - 1);
      if (m_state == 1) m_presc = tick ? 0 : m_presc + 1;
      if (lp) begin
        m_lap = m_cnt;
        m_lap_act = 1;
      end else if (rp) begin
        m_lap_act = 0;
      end
      nstate = m_state;
      if (up_p) begin
        if (m_state == 0) nstate = 1;
        else if (m_state == 1) nstate = 2;
        else if (!m_ovf) nstate = 1;
      end
      if (tick) begin
        if (m_cnt == MaxCs) begin
          if (Sat) begin
            m_ovf = 1;
            nstate = 2;
          end else begin
            m_cnt = 0;
          end
        end else begin
          m_cnt++;
        end
      end
      m_state = nstate;
    end
    p_l = left; p_d = down; p_r = right; p_u = up;
    m_disp = nd;
  endtask

  task automatic check_outputs();
    check_eq("disp", disp, m_disp);
    check_eq("running", running, m_state == 1);
    check_eq("lap_active", lap_active, m_lap_act);
`ifdef SW_SATURATE_EN
    check_eq("overflow", overflow, m_ovf);
`endif
  endtask

  // Drive at negedge, step the model on posedge, compare at the next negedge.
  task automatic cycle(input logic l, input logic d, input logic r, input logic u);
    left = l; down = d; right = r; up = u;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    left = 0; down = 0; right = 0; up = 0;
    rst_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Held up key gives one toggle; then count for a while.
    repeat (3) cycle(0, 0, 0, 1);
    repeat (20) cycle(0, 0, 0, 0);
    // down while running is ignored
    cycle(0, 1, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    // pause, wait, resume (prescaler retained)
    cycle(0, 0, 0, 1);
    repeat (20) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (9) cycle(0, 0, 0, 0);
    // lap capture, release, then both on one edge
    cycle(1, 0, 0, 0);
    repeat (10) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);
    // pause then clear one clock later
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Randomized key activity with held levels.
    for (int n = 0; n < 3000; n++) begin
      logic l, d, r, u;
      l = left; d = down; r = right; u = up;
      if ($urandom_range(11, 0) == 0) l = ~l;
      if ($urandom_range(39, 0) == 0) d = ~d;
      if ($urandom_range(11, 0) == 0) r = ~r;
      if ($urandom_range(15, 0) == 0) u = ~u;
      cycle(l, d, r, u);
    end

    // Rollover: pause, preload 59:59.98, resume across the max.
    do_reset();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    force dut.cnt_q = 24'h595998;
    m_cnt = MaxCs - 1;
    cycle(0, 0, 0, 0);
    release dut.cnt_q;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (12) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Asynchronous reset between edges at 00:12.34.
    do_reset();
    cycle(0, 0, 0, 1);
    begin
      int n;
      n = 0;
      while (m_cnt != 1234 && n < 6000) begin
        cycle(0, 0, 0, 0);
        n++;
      end
    end
    cycle(0, 0, 0, 0);
    check_eq("disp_at_1234", disp, 24'h001234);
    #2;
    rst_n = 0;
    #1;
    check_eq("async_disp", disp, 24'h000000);
    check_eq("async_running", running, 1'b0);
    check_eq("async_lap_active", lap_active, 1'b0);
`ifdef SW_SATURATE_EN
    check_eq("async_overflow", overflow, 1'b0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (5) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (6) cycle(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
